irda_mir_crc_tx_ctrl: RTL

- Transmit-side sequencer for the MIR CRC-CCITT16 serial generator.
- Takes bytes from the TX FIFO and serialises them one bit per `mir_txbit_enable` tick onto the generator's data input.
- Clears the CRC at frame start, then switches the generator into CRC-output mode for exactly 16 ticks after the last byte.
- Reports completion, underrun and abort to the MIR framer.

---
 rtl/irda_mir_crc_tx_ctrl_if.sv | 22 ++
 rtl/irda_mir_crc_tx_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/irda_mir_crc_tx_ctrl_if.sv
// TX FIFO to MIR CRC transmit sequencer byte handshake.
// The FIFO side is the master; the sequencer pops with a one-clk tx_ready strobe.
interface irda_mir_crc_tx_ctrl_if;
   logic [7:0] tx_byte;
   logic       tx_valid;
   logic       tx_last;
   logic       tx_ready;

   modport master (
      output tx_byte,
      output tx_valid,
      output tx_last,
      input  tx_ready
   );

   modport slave (
      input  tx_byte,
      input  tx_valid,
      input  tx_last,
      output tx_ready
   );
endinterface

// File: rtl/irda_mir_crc_tx_ctrl.sv
// MIR transmit sequencer: serialises FIFO bytes into the CRC-CCITT16 generator,
// then runs the generator in CRC-output mode for 16 bit ticks.
module irda_mir_crc_tx_ctrl #(
   parameter int LSB_FIRST = 1,
   parameter int CNT_W     = 12
) (
   input  logic                 clk,
   input  logic                 wb_rst_n_i,
   input  logic                 mir_txbit_enable,
   irda_mir_crc_tx_ctrl_if.slave fifo,
   input  logic                 bad_crc_req,
   input  logic                 abort,
   output logic                 clrcrc,
   output logic                 txdin,
   output logic                 crcndata,
   output logic                 bdcrc,
   output logic                 busy,
   output logic                 done,
   output logic                 underrun,
   output logic [CNT_W-1:0]     frame_bytes
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DATA,
      S_CRC,
      S_DONE
   } state_t;

   state_t           r_state, w_state_next;
   logic [7:0]       r_shreg, w_shreg_next;
   logic             r_last_f, w_last_f_next;
   logic [2:0]       r_bitcnt, w_bitcnt_next;
   logic [3:0]       r_crccnt, w_crccnt_next;
   logic             r_clrcrc, w_clrcrc_next;
   logic             r_txdin, w_txdin_next;
   logic             r_crcndata, w_crcndata_next;
   logic             r_bdcrc, w_bdcrc_next;
   logic             r_busy, w_busy_next;
   logic             r_done, w_done_next;
   logic             r_underrun, w_underrun_next;
   logic             r_tx_ready, w_tx_ready_next;
   logic [CNT_W-1:0] r_frame_bytes, w_frame_bytes_next;

   logic [7:0]       w_shift;
   logic             w_next_bit;
   logic             w_first_bit;

   // Bit order only changes which end of the byte feeds txdin; the shift
   // rotates so every shreg bit stays live.
   generate
      if (LSB_FIRST != 0) begin : g_lsb_first
         assign w_shift     = {r_shreg[0], r_shreg[7:1]};
         assign w_next_bit  = r_shreg[1];
         assign w_first_bit = fifo.tx_byte[0];
      end else begin : g_msb_first
         assign w_shift     = {r_shreg[6:0], r_shreg[7]};
         assign w_next_bit  = r_shreg[6];
         assign w_first_bit = fifo.tx_byte[7];
      end
   endgenerate

   always_comb begin
      w_state_next       = r_state;
      w_shreg_next       = r_shreg;
      w_last_f_next      = r_last_f;
      w_bitcnt_next      = r_bitcnt;
      w_crccnt_next      = r_crccnt;
      w_txdin_next       = r_txdin;
      w_crcndata_next    = r_crcndata;
      w_bdcrc_next       = r_bdcrc;
      w_busy_next        = r_busy;
      w_frame_bytes_next = r_frame_bytes;
      w_clrcrc_next      = 1'b0;
      w_tx_ready_next    = 1'b0;
      w_done_next        = 1'b0;
      w_underrun_next    = 1'b0;

      if (abort && (r_state == S_LOAD || r_state == S_DATA || r_state == S_CRC)) begin
         w_state_next    = S_IDLE;
         w_txdin_next    = 1'b0;
         w_crcndata_next = 1'b0;
         w_bdcrc_next    = 1'b0;
         w_busy_next     = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (fifo.tx_valid) begin
                  w_state_next    = S_LOAD;
                  w_clrcrc_next   = 1'b1;
                  w_tx_ready_next = 1'b1;
                  w_busy_next     = 1'b1;
               end
            end
            S_LOAD: begin
               w_shreg_next       = fifo.tx_byte;
               w_last_f_next      = fifo.tx_last;
               w_bdcrc_next       = bad_crc_req;
               w_frame_bytes_next = CNT_W'(1);
               w_bitcnt_next      = 3'd0;
               w_txdin_next       = w_first_bit;
               w_crcndata_next    = 1'b0;
               w_state_next       = S_DATA;
            end
            S_DATA: begin
               if (mir_txbit_enable) begin
                  if (r_bitcnt != 3'd7) begin
                     w_shreg_next  = w_shift;
                     w_bitcnt_next = r_bitcnt + 3'd1;
                     w_txdin_next  = w_next_bit;
                  end else if (r_last_f) begin
                     w_state_next    = S_CRC;
                     w_crccnt_next   = 4'd0;
                     w_crcndata_next = 1'b1;
                     w_txdin_next    = 1'b0;
                  end else if (fifo.tx_valid) begin
                     // Byte is captured on this tick; the pop strobe follows
                     // one clk later while the FIFO head still holds it.
                     w_tx_ready_next = 1'b1;
                     w_shreg_next    = fifo.tx_byte;
                     w_last_f_next   = fifo.tx_last;
                     w_bitcnt_next   = 3'd0;
                     w_txdin_next    = w_first_bit;
                     if (r_frame_bytes != {CNT_W{1'b1}}) begin
                        w_frame_bytes_next = r_frame_bytes + CNT_W'(1);
                     end
                  end else begin
                     w_underrun_next = 1'b1;
                     w_state_next    = S_IDLE;
                     w_txdin_next    = 1'b0;
                     w_bdcrc_next    = 1'b0;
                     w_busy_next     = 1'b0;
                  end
               end
            end
            S_CRC: begin
               if (mir_txbit_enable) begin
                  if (r_crccnt == 4'd15) begin
                     w_state_next    = S_DONE;
                     w_crcndata_next = 1'b0;
                     w_bdcrc_next    = 1'b0;
                     w_txdin_next    = 1'b0;
                     w_done_next     = 1'b1;
                     w_busy_next     = 1'b0;
                  end else begin
                     w_crccnt_next = r_crccnt + 4'd1;
                  end
               end
            end
            S_DONE: begin
               w_state_next = S_IDLE;
            end
            default: begin
               w_state_next = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!wb_rst_n_i) begin
         r_state       <= S_IDLE;
         r_shreg       <= 8'd0;
         r_last_f      <= 1'b0;
         r_bitcnt      <= 3'd0;
         r_crccnt      <= 4'd0;
         r_clrcrc      <= 1'b0;
         r_txdin       <= 1'b0;
         r_crcndata    <= 1'b0;
         r_bdcrc       <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_underrun    <= 1'b0;
         r_tx_ready    <= 1'b0;
         r_frame_bytes <= '0;
      end else begin
         r_state       <= w_state_next;
         r_shreg       <= w_shreg_next;
         r_last_f      <= w_last_f_next;
         r_bitcnt      <= w_bitcnt_next;
         r_crccnt      <= w_crccnt_next;
         r_clrcrc      <= w_clrcrc_next;
         r_txdin       <= w_txdin_next;
         r_crcndata    <= w_crcndata_next;
         r_bdcrc       <= w_bdcrc_next;
         r_busy        <= w_busy_next;
         r_done        <= w_done_next;
         r_underrun    <= w_underrun_next;
         r_tx_ready    <= w_tx_ready_next;
         r_frame_bytes <= w_frame_bytes_next;
      end
   end

   assign clrcrc        = r_clrcrc;
   assign txdin         = r_txdin;
   assign crcndata      = r_crcndata;
   assign bdcrc         = r_bdcrc;
   assign busy          = r_busy;
   assign done          = r_done;
   assign underrun      = r_underrun;
   assign frame_bytes   = r_frame_bytes;
   assign fifo.tx_ready = r_tx_ready;

endmodule
